// File: rtl/seg7_pkg.sv
// Shared constants and types for the 7-segment display blocks.
package seg7_pkg;

  localparam int unsigned NDIG_DEF    = 4;
  localparam int unsigned DIV_W_DEF   = 17;
  localparam int unsigned DIV_MAX_DEF = 99999;
  localparam int unsigned GUARD_DEF   = 4;

  // Board drives anodes and segments active-low.
  localparam logic ANODE_ON = 1'b0;
  localparam logic SEG_ON   = 1'b0;

  typedef logic [3:0] nibble_t;

  // Index counter width; a single digit still needs one bit.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/seg7_prescaler.sv
// Free-running 0..DIV_MAX counter with a wrap strobe on the terminal count.
module seg7_prescaler #(
  parameter int unsigned DIV_W   = 17,
  parameter int unsigned DIV_MAX = 99999
) (
  input  logic             clk,
  input  logic             rst_n,
  output logic [DIV_W-1:0] cnt,
  output logic             wrap
);

  localparam logic [DIV_W-1:0] MAX_C = DIV_W'(DIV_MAX);
  localparam logic [DIV_W-1:0] ONE_C = DIV_W'(1);

  logic [DIV_W-1:0] cnt_q;
  logic [DIV_W-1:0] cnt_d;

  always_comb begin
    wrap  = (cnt_q == MAX_C);
    cnt_d = wrap ? '0 : cnt_q + ONE_C;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/seg7_scan_mux.sv
// Scans NDIG digits onto one shared decoder nibble with active-low anodes,
// double-buffered loading, anti-ghosting guard and leading-zero blanking.
module seg7_scan_mux
  import seg7_pkg::*;
#(
  parameter int unsigned NDIG    = NDIG_DEF,
  parameter int unsigned DIV_W   = DIV_W_DEF,
  parameter int unsigned DIV_MAX = DIV_MAX_DEF,
  parameter int unsigned GUARD   = GUARD_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic [4*NDIG-1:0] din,
  input  logic [NDIG-1:0]   dp_in,
  input  logic              blank_lz,
  output logic [3:0]        nib_out,
  output logic [NDIG-1:0]   an_n,
  output logic              dp_n,
  output logic              pending,
  output logic              tick
);

  localparam int unsigned      IDX_W    = idx_width(NDIG);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NDIG - 1);
  localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);
  localparam logic [DIV_W-1:0] GUARD_C  = DIV_W'(GUARD);

  logic [DIV_W-1:0]  cnt;
  logic              wrap;

  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [4*NDIG-1:0] disp_q, disp_d;
  logic [NDIG-1:0]   disp_dp_q, disp_dp_d;
  logic [4*NDIG-1:0] pend_q, pend_d;
  logic [NDIG-1:0]   pend_dp_q, pend_dp_d;
  logic              pending_q, pending_d;

  nibble_t           nib_q, nib_d;
  logic [NDIG-1:0]   an_n_q, an_n_d;
  logic              dp_n_q, dp_n_d;
  logic              tick_q, tick_d;

  logic              frame_end;
  logic              all_zero;
  logic [NDIG-1:0]   zero_run;
  logic [NDIG-1:0]   blanked;
  nibble_t           cur_nib;
  logic              cur_dp;
  logic              cur_blank;
  logic              an_on;

  seg7_prescaler #(
    .DIV_W   (DIV_W),
    .DIV_MAX (DIV_MAX)
  ) u_prescaler (
    .clk   (clk),
    .rst_n (rst_n),
    .cnt   (cnt),
    .wrap  (wrap)
  );

  // Commit is evaluated before load so a load on the boundary cycle lands in
  // pend and stays pending, while the old pend goes to the display.
  always_comb begin
    frame_end = wrap && (idx_q == IDX_LAST);

    idx_d = idx_q;
    if (wrap) begin
      idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_ONE;
    end

    disp_d    = disp_q;
    disp_dp_d = disp_dp_q;
    pend_d    = pend_q;
    pend_dp_d = pend_dp_q;
    pending_d = pending_q;

    if (frame_end && pending_q) begin
      disp_d    = pend_q;
      disp_dp_d = pend_dp_q;
      pending_d = 1'b0;
    end

    if (load) begin
      pend_d    = din;
      pend_dp_d = dp_in;
      pending_d = 1'b1;
    end
  end

  // zero_run[i]: displayed digits NDIG-1 down to i are all zero.
  always_comb begin
    all_zero = 1'b1;
    zero_run = '0;
    for (int unsigned k = 0; k < NDIG; k++) begin
      all_zero = all_zero && (disp_q[4*(NDIG-1-k) +: 4] == 4'h0);
      zero_run[NDIG-1-k] = all_zero;
    end
    blanked = blank_lz ? (zero_run & ~NDIG'(1)) : '0;
  end

  always_comb begin
    cur_nib   = '0;
    cur_dp    = 1'b0;
    cur_blank = 1'b0;
    for (int unsigned i = 0; i < NDIG; i++) begin
      if (idx_q == IDX_W'(i)) begin
        cur_nib   = disp_q[4*i +: 4];
        cur_dp    = disp_dp_q[i];
        cur_blank = blanked[i];
      end
    end

    an_on = (cnt >= GUARD_C) && !cur_blank;

    an_n_d = {NDIG{~ANODE_ON}};
    for (int unsigned i = 0; i < NDIG; i++) begin
      if (an_on && (idx_q == IDX_W'(i))) begin
        an_n_d[i] = ANODE_ON;
      end
    end

    nib_d  = cur_nib;
    dp_n_d = (cur_dp && an_on) ? SEG_ON : ~SEG_ON;
    tick_d = wrap;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      idx_q     <= '0;
      disp_q    <= '0;
      disp_dp_q <= '0;
      pend_q    <= '0;
      pend_dp_q <= '0;
      pending_q <= 1'b0;
      nib_q     <= '0;
      an_n_q    <= {NDIG{~ANODE_ON}};
      dp_n_q    <= ~SEG_ON;
      tick_q    <= 1'b0;
    end else begin
      idx_q     <= idx_d;
      disp_q    <= disp_d;
      disp_dp_q <= disp_dp_d;
      pend_q    <= pend_d;
      pend_dp_q <= pend_dp_d;
      pending_q <= pending_d;
      nib_q     <= nib_d;
      an_n_q    <= an_n_d;
      dp_n_q    <= dp_n_d;
      tick_q    <= tick_d;
    end
  end

  assign nib_out = nib_q;
  assign an_n    = an_n_q;
  assign dp_n    = dp_n_q;
  assign pending = pending_q;
  assign tick    = tick_q;

endmodule

// File: tb/tb_seg7_scan_mux.sv
// Directed bench for seg7_scan_mux with a cycle scoreboard checked every negedge.
module tb_seg7_scan_mux;

  localparam int NDIG    = 4;
  localparam int DIV_W   = 4;
  localparam int DIV_MAX = 3;
  localparam int GUARD   = 1;
  localparam int FRAME   = NDIG * (DIV_MAX + 1);

  logic        clk      = 1'b0;
  logic        rst_n    = 1'b0;
  logic        load     = 1'b0;
  logic        blank_lz = 1'b0;
  logic [15:0] din      = '0;
  logic [3:0]  dp_in    = '0;
  logic [3:0]  nib_out;
  logic [3:0]  an_n;
  logic        dp_n;
  logic        pending;
  logic        tick;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  seg7_scan_mux #(
    .NDIG    (NDIG),
    .DIV_W   (DIV_W),
    .DIV_MAX (DIV_MAX),
    .GUARD   (GUARD)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (load),
    .din      (din),
    .dp_in    (dp_in),
    .blank_lz (blank_lz),
    .nib_out  (nib_out),
    .an_n     (an_n),
    .dp_n     (dp_n),
    .pending  (pending),
    .tick     (tick)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  typedef struct packed {
    logic [3:0] nib;
    logic [3:0] an;
    logic       dp;
    logic       tk;
    logic       pend;
  } exp_t;

  exp_t sb[$];

  int          m_cnt     = 0;
  int          m_idx     = 0;
  logic [15:0] m_disp    = '0;
  logic [15:0] m_pend    = '0;
  logic [3:0]  m_dp      = '0;
  logic [3:0]  m_pend_dp = '0;
  logic        m_pending = 1'b0;

  // Reference model: expected registered outputs for the state before this edge.
  always @(posedge clk) begin : model
    exp_t        e;
    bit          on;
    bit          blk;
    logic [15:0] sh;
    if (!rst_n) begin
      m_cnt = 0; m_idx = 0; m_disp = '0; m_pend = '0;
      m_dp = '0; m_pend_dp = '0; m_pending = 1'b0;
      e = '{nib: 4'h0, an: 4'hF, dp: 1'b1, tk: 1'b0, pend: 1'b0};
    end else begin
      sh    = m_disp >> (4 * m_idx);
      blk   = blank_lz && (m_idx != 0) && (sh == 16'h0);
      on    = (m_cnt >= GUARD) && !blk;
      e.nib = sh[3:0];
      e.an  = on ? ~(4'b0001 << m_idx) : 4'hF;
      e.dp  = !(m_dp[m_idx] && on);
      e.tk  = (m_cnt == DIV_MAX);
      if (m_cnt == DIV_MAX && m_idx == NDIG - 1 && m_pending) begin
        m_disp = m_pend; m_dp = m_pend_dp; m_pending = 1'b0;
      end
      if (load) begin
        m_pend = din; m_pend_dp = dp_in; m_pending = 1'b1;
      end
      if (m_cnt == DIV_MAX) m_idx = (m_idx + 1) % NDIG;
      m_cnt  = (m_cnt + 1) % (DIV_MAX + 1);
      e.pend = m_pending;
    end
    sb.push_back(e);
  end

  always @(negedge clk) begin : scoreboard
    exp_t e;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk("sb_nib", nib_out, e.nib);
      chk("sb_an_n", an_n, e.an);
      chk("sb_dp_n", dp_n, e.dp);
      chk("sb_tick", tick, e.tk);
      chk("sb_pending", pending, e.pend);
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic do_load(input logic [15:0] d, input logic [3:0] dp);
    din   = d;
    dp_in = dp;
    load  = 1'b1;
    step();
    load  = 1'b0;
    chk("pending_set", pending, 1);
  endtask

  task automatic wait_commit(input string tag);
    int n;
    n = 0;
    do begin
      step();
      n++;
    end while (pending !== 1'b0 && n < 4 * FRAME);
    chk(tag, pending, 0);
  endtask

  initial begin : stim
    int          n;
    int          idx;
    int          cnt;
    int          lows;
    logic [15:0] val;
    logic [15:0] sh;
    logic [3:0]  an_exp;
    logic [3:0]  seen_low;

    // Reset and first tick
    rst_n = 1'b0;
    repeat (3) step();
    chk("rst_an_n", an_n, 4'hF);
    chk("rst_dp_n", dp_n, 1);
    chk("rst_nib", nib_out, 0);
    chk("rst_pending", pending, 0);
    chk("rst_tick", tick, 0);
    rst_n = 1'b1;
    n = 0;
    do begin
      step();
      n++;
    end while (tick !== 1'b1 && n < 20);
    chk("tick_first", n, 4);

    // Plain scan of 1234
    do_load(16'h1234, 4'b0000);
    wait_commit("commit_1234");
    val = 16'h1234;
    for (int k = 0; k < FRAME; k++) begin
      step();
      idx    = k / (DIV_MAX + 1);
      cnt    = k % (DIV_MAX + 1);
      sh     = val >> (4 * idx);
      an_exp = (cnt < GUARD) ? 4'hF : ~(4'b0001 << idx);
      chk("s2_nib", nib_out, sh[3:0]);
      chk("s2_an_n", an_n, an_exp);
    end

    // Leading-zero blanking on 0050
    blank_lz = 1'b1;
    do_load(16'h0050, 4'b0000);
    wait_commit("commit_0050");
    seen_low = '0;
    for (int k = 0; k < FRAME; k++) begin
      step();
      seen_low = seen_low | ~an_n;
    end
    chk("s3_lit_blank", seen_low, 4'b0011);
    blank_lz = 1'b0;
    step();
    seen_low = '0;
    for (int k = 0; k < FRAME; k++) begin
      step();
      seen_low = seen_low | ~an_n;
    end
    chk("s3_lit_noblank", seen_low, 4'b1111);

    // Load exactly on the frame boundary cycle
    do_load(16'hAAAA, 4'b0000);
    wait_commit("commit_aaaa");
    n = 0;
    while (!(m_cnt == DIV_MAX && m_idx == NDIG - 1) && n < 4 * FRAME) begin
      step();
      n++;
    end
    chk("s4_found_boundary", n < 4 * FRAME, 1);
    din  = 16'hBBBB;
    load = 1'b1;
    step();
    load = 1'b0;
    chk("s4_pending_kept", pending, 1);
    for (int k = 0; k < FRAME; k++) begin
      step();
      chk("s4_old_frame", nib_out, 4'hA);
    end
    chk("s4_pending_clr", pending, 0);
    step();
    chk("s4_new_frame", nib_out, 4'hB);

    // Decimal point tracks its anode, suppressed when the digit is blanked
    do_load(16'h1234, 4'b0100);
    wait_commit("commit_dp");
    lows = 0;
    for (int k = 0; k < FRAME; k++) begin
      step();
      chk("s5_dp_track", dp_n, an_n[2]);
      if (dp_n === 1'b0) lows++;
    end
    chk("s5_dp_count", lows, DIV_MAX + 1 - GUARD);
    blank_lz = 1'b1;
    do_load(16'h0001, 4'b0100);
    wait_commit("commit_dp_blank");
    for (int k = 0; k < FRAME; k++) begin
      step();
      chk("s5_dp_blank", dp_n, 1);
      chk("s5_an2_blank", an_n[2], 1);
    end

    // Reset mid-frame with data pending
    blank_lz = 1'b0;
    do_load(16'h5678, 4'b0000);
    n = 0;
    while (m_idx != 2 && n < 4 * FRAME) begin
      step();
      n++;
    end
    chk("s6_pending_pre", pending, 1);
    rst_n = 1'b0;
    step();
    chk("s6_rst_an_n", an_n, 4'hF);
    chk("s6_rst_nib", nib_out, 0);
    chk("s6_rst_dp_n", dp_n, 1);
    chk("s6_rst_pending", pending, 0);
    chk("s6_rst_tick", tick, 0);
    rst_n = 1'b1;
    n = 0;
    do begin
      step();
      n++;
    end while (an_n === 4'hF && n < 20);
    chk("s6_restart_an_n", an_n, 4'b1110);
    chk("s6_restart_nib", nib_out, 0);
    chk("s6_restart_pending", pending, 0);

    repeat (FRAME) step();
    chk("sb_drained", sb.size() < 2, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

endmodule
